// File: rtl/cla_seq_pkg.sv
// -----------------------------------------------------------------------------
// cla_seq_pkg
// Shared types and constants for the sequential carry-lookahead adder.
//   state_t    : sequencer state encoding (IDLE, RUN, DONE)
//   NIB_BITS   : width of the single carry-lookahead slice
//   idx_width(): bit width needed to count nibble steps (at least 1)
// -----------------------------------------------------------------------------
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_BITS = 4;

    // ceil(log2(nib)), clamped to 1 so a single-nibble build still has a
    // legal index register.
    function automatic int idx_width(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/cla_seq_adder_slice.sv
// -----------------------------------------------------------------------------
// cla_nibble_slice
// Combinational 4-bit carry-lookahead adder.
//   a, b : nibble operands
//   ci   : carry in
//   s    : nibble sum
//   co   : carry out of bit 3
// -----------------------------------------------------------------------------
module cla_nibble_slice
    import cla_seq_pkg::*;
(
    input  logic [NIB_BITS-1:0] a,
    input  logic [NIB_BITS-1:0] b,
    input  logic                ci,
    output logic [NIB_BITS-1:0] s,
    output logic                co
);

    logic [NIB_BITS-1:0] g;
    logic [NIB_BITS-1:0] p;
    logic [NIB_BITS:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded directly from ci, so no carry ripples
    // through an earlier stage.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[NIB_BITS-1:0];
    assign co = c[NIB_BITS];

endmodule

// File: rtl/cla_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_seq_adder
// Drives one 4-bit carry-lookahead slice across a WIDTH-bit operand pair,
// one nibble per cycle, LSB first. It supports add/subtract and produces
// carry-out and signed-overflow flags.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake
//   op_a, op_b          : operands
//   sub                 : 1 = A-B, 0 = A+B+cin
//   cin                 : carry in for add (ignored for subtract)
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, carry out (1 = no borrow on sub), overflow
//   zero                : result is zero (only with CLA_SEQ_ZERO_FLAG_EN)
//
// Optional feature macro: CLA_SEQ_ZERO_FLAG_EN adds the zero output.
// -----------------------------------------------------------------------------
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef CLA_SEQ_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NIB = WIDTH / NIB_BITS;
    localparam int IW  = idx_width(NIB);

    generate
        if ((WIDTH % NIB_BITS) != 0 || WIDTH < NIB_BITS) begin : g_bad_width
            $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t                state_reg;
    logic [IW-1:0]         idx_reg;
    logic                  carry_reg;
    logic [WIDTH-1:0]      a_reg;
    logic [WIDTH-1:0]      b_reg;
    logic [WIDTH-1:0]      sum_reg;
    logic                  cout_reg;
    logic                  ovf_reg;
    logic                  in_ready_reg;
    logic                  out_valid_reg;
`ifdef CLA_SEQ_ZERO_FLAG_EN
    logic                  zero_reg;
`endif

    // Nibble views of the latched operands, selected by the step index.
    logic [NIB_BITS-1:0]   a_nib [NIB];
    logic [NIB_BITS-1:0]   b_nib [NIB];

    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*NIB_BITS +: NIB_BITS];
            assign b_nib[gi] = b_reg[gi*NIB_BITS +: NIB_BITS];
        end
    endgenerate

    logic [NIB_BITS-1:0]   slice_a;
    logic [NIB_BITS-1:0]   slice_b;
    logic [NIB_BITS-1:0]   slice_sum;
    logic                  slice_co;
    logic                  last_step;

    assign slice_a   = a_nib[idx_reg];
    assign slice_b   = b_nib[idx_reg];
    assign last_step = (idx_reg == IW'(NIB - 1));

    cla_nibble_slice u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_reg),
        .s  (slice_sum),
        .co (slice_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
`ifdef CLA_SEQ_ZERO_FLAG_EN
            zero_reg      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= op_a;
                        // Subtraction is A + ~B + 1.
                        b_reg        <= sub ? ~op_b : op_b;
                        carry_reg    <= sub ? 1'b1 : cin;
                        idx_reg      <= '0;
                        sum_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
`ifdef CLA_SEQ_ZERO_FLAG_EN
                        zero_reg     <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (idx_reg == IW'(i)) begin
                            sum_reg[i*NIB_BITS +: NIB_BITS] <= slice_sum;
                        end
                    end
                    carry_reg <= slice_co;
                    idx_reg   <= idx_reg + 1'b1;
`ifdef CLA_SEQ_ZERO_FLAG_EN
                    zero_reg  <= zero_reg && (slice_sum == '0);
`endif
                    if (last_step) begin
                        cout_reg      <= slice_co;
                        // Operands agree in sign but the result MSB does not.
                        ovf_reg       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                         (slice_sum[NIB_BITS-1] != a_reg[WIDTH-1]);
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
`ifdef CLA_SEQ_ZERO_FLAG_EN
    assign zero      = zero_reg;
`endif

endmodule
